lfsr_period_monitor: RTL

LFSR_PERIOD_MONITOR -- requirements
Module: lfsr_period_monitor

---
 rtl/lfsr_mon_pkg.sv | 21 ++
 rtl/lfsr_period_monitor_period_counter.sv | 29 ++
 rtl/lfsr_period_monitor.sv | 131 +++++++++++++
 3 files changed

// File: rtl/lfsr_mon_pkg.sv
// Shared types and constants for the LFSR period monitor: FSM state encoding, error codes, counter limit.
// Pure declarations, no logic; imported by the monitor top and its period counter.
package lfsr_mon_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_COUNT   = 3'd3,
    ST_DONE    = 3'd4,
    ST_ERROR   = 3'd5
  } state_e;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_LOCKUP  = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  localparam int         CNT_W   = 5;
  localparam logic [4:0] MAX_CNT = 5'd31;

endpackage

// File: rtl/lfsr_period_monitor_period_counter.sv
// Saturating 5-bit cycle counter with clear-to-0, init-to-1 and at_max flag.
// Single-cycle update; no backpressure, inc at MAX_CNT holds the value instead of wrapping.
module period_counter
  import lfsr_mon_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             init,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             at_max
);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (init) begin
      cnt <= 5'd1;
    end else if (inc && (cnt != MAX_CNT)) begin
      cnt <= cnt + 5'd1;
    end
  end

  assign at_max = (cnt == MAX_CNT);

endmodule

// File: rtl/lfsr_period_monitor.sv
// Loads a seed into an external 4-bit LFSR and measures its period; LFSR_MON_LOCKUP_EN adds an all-zero lockup check.
// done arrives period+3 cycles after an accepted start; start while busy is dropped, never queued.
module lfsr_period_monitor
  import lfsr_mon_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] seed_in,
  input  logic [3:0] lfsr_q,
  output logic       lfsr_sel,
  output logic [3:0] lfsr_seed,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] err_code,
  output logic [4:0] period
);

  localparam logic [2:0] S_IDLE    = ST_IDLE;
  localparam logic [2:0] S_LOAD    = ST_LOAD;
  localparam logic [2:0] S_CAPTURE = ST_CAPTURE;
  localparam logic [2:0] S_COUNT   = ST_COUNT;
  localparam logic [2:0] S_DONE    = ST_DONE;
  localparam logic [2:0] S_ERROR   = ST_ERROR;

  logic [2:0]       state_q;
  logic [2:0]       state_d;
  logic [3:0]       seed_q;
  logic [3:0]       ref_q;
  logic [CNT_W-1:0] cnt;
  logic             at_max;

  logic accept;
  logic lockup_hit;
  logic match_hit;
  logic timeout_hit;
  logic cnt_clr;
  logic cnt_init;
  logic cnt_inc;

  assign accept = (state_q == S_IDLE) && start;

`ifdef LFSR_MON_LOCKUP_EN
  assign lockup_hit = (state_q == S_CAPTURE) && (lfsr_q == 4'b0000);
`else
  assign lockup_hit = 1'b0;
`endif

  // Match wins over timeout when both are true on the same COUNT cycle.
  assign match_hit   = (state_q == S_COUNT) && (lfsr_q == ref_q);
  assign timeout_hit = (state_q == S_COUNT) && !match_hit && at_max;

  always_comb begin
    state_d  = state_q;
    cnt_clr  = 1'b0;
    cnt_init = 1'b0;
    cnt_inc  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          cnt_clr = 1'b1;
        end
      end
      S_LOAD:    state_d = S_CAPTURE;
      S_CAPTURE: begin
        cnt_init = 1'b1;
        state_d  = lockup_hit ? S_ERROR : S_COUNT;
      end
      S_COUNT: begin
        if (match_hit) begin
          state_d = S_DONE;
        end else if (timeout_hit) begin
          state_d = S_ERROR;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERROR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      seed_q   <= 4'b0000;
      ref_q    <= 4'b0000;
      err_code <= ERR_NONE;
      period   <= 5'd0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        seed_q   <= seed_in;
        err_code <= ERR_NONE;
        period   <= 5'd0;
      end
      if (state_q == S_CAPTURE) begin
        ref_q <= lfsr_q;
      end
      if (lockup_hit) begin
        err_code <= ERR_LOCKUP;
      end
      if (match_hit) begin
        period <= cnt;
      end
      if (timeout_hit) begin
        err_code <= ERR_TIMEOUT;
      end
    end
  end

  period_counter u_period_counter (
    .clk    (clk),
    .reset  (reset),
    .clr    (cnt_clr),
    .init   (cnt_init),
    .inc    (cnt_inc),
    .cnt    (cnt),
    .at_max (at_max)
  );

  assign busy      = (state_q != S_IDLE);
  assign lfsr_sel  = (state_q == S_LOAD);
  assign lfsr_seed = lfsr_sel ? seed_q : 4'b0000;
  assign done      = (state_q == S_DONE);
  assign err       = (state_q == S_ERROR);

endmodule
